// File: rtl/fir_stream_feeder_pkg.sv
// Shared definitions for the FIR stream feeder: default sizes, FSM states,
// and the {valid,last} tag that travels alongside each sample.
package fir_stream_feeder_pkg;

    localparam int unsigned DATA_W_DEF      = 13;
    localparam int unsigned FIFO_DEPTH_DEF  = 16;
    localparam int unsigned NUM_TAPS_DEF    = 34;
    localparam int unsigned FIR_LATENCY_DEF = 68;
    localparam int unsigned CNT_W_DEF       = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Tag carried through the FIR-latency pipeline
    typedef struct packed {
        logic v;
        logic l;
    } tag_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-valid output.
// Ports: clk, rst (sync, active-high), push/din/full on the write side,
//        pop/dout/empty on the read side. dout is valid whenever !empty.
// A push while full is accepted only together with a pop (pass-through).
module sync_fifo #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage: no reset needed, contents qualified by the pointers
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fir_stream_feeder.sv
// Drive side of a free-running symmetric FIR: buffers upstream sample blocks,
// feeds fir_x every cycle, appends NUM_TAPS-1 zero tail samples per block,
// and re-aligns fir_dataout into a valid/last stream via a tag pipeline.
// Ports: s_valid/s_data/s_last/s_ready  upstream handshake
//        fir_x / fir_dataout             FIR input / output
//        m_valid/m_data/m_last           aligned output stream (no backpressure)
//        underrun_cnt                    saturating count of starved STREAM cycles
//        busy                            FSM not in IDLE
module fir_stream_feeder
    import fir_stream_feeder_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int unsigned NUM_TAPS    = NUM_TAPS_DEF,
    parameter int unsigned FIR_LATENCY = FIR_LATENCY_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] fir_x,
    input  logic [DATA_W-1:0] fir_dataout,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [CNT_W-1:0]  underrun_cnt,
    output logic              busy
);

    localparam int unsigned WORD_W = DATA_W + 1;
    localparam int unsigned FL_W   = $clog2(NUM_TAPS);
    localparam int unsigned DR_W   = $clog2(FIR_LATENCY + 1);

    state_t            state;
    state_t            state_d;
    logic [DATA_W-1:0] x_d;
    tag_t              tag_x;
    tag_t              tag_d;
    logic [FL_W-1:0]   flush_cnt;
    logic [FL_W-1:0]   flush_d;
    logic [DR_W-1:0]   drain_cnt;
    logic [DR_W-1:0]   drain_d;
    logic [CNT_W-1:0]  under_d;
    tag_t              tag_pipe [FIR_LATENCY];

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_dout;

    // Not ready while reset is applied, otherwise only gated by FIFO space
    assign s_ready   = !fifo_full && !rst;
    assign fifo_push = s_valid && s_ready;
    assign busy      = (state != ST_IDLE);

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   ({s_last, s_data}),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d  = state;
        x_d      = '0;
        tag_d    = '0;
        flush_d  = flush_cnt;
        drain_d  = drain_cnt;
        under_d  = underrun_cnt;
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    x_d      = fifo_dout[DATA_W-1:0];
                    tag_d.v  = 1'b1;
                    if (fifo_dout[DATA_W]) begin
                        state_d = ST_FLUSH;
                        flush_d = FL_W'(NUM_TAPS - 2);
                    end
                end else if (underrun_cnt != '1) begin
                    // Starved: a zero goes into the filter untagged
                    under_d = underrun_cnt + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                tag_d.v = 1'b1;
                tag_d.l = (flush_cnt == '0);
                if (flush_cnt == '0) begin
                    state_d = ST_DRAIN;
                    drain_d = DR_W'(FIR_LATENCY - 1);
                end else begin
                    flush_d = flush_cnt - FL_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_cnt - DR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and FIR-input registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            fir_x        <= '0;
            tag_x        <= '0;
            flush_cnt    <= '0;
            drain_cnt    <= '0;
            underrun_cnt <= '0;
        end else begin
            state        <= state_d;
            fir_x        <= x_d;
            tag_x        <= tag_d;
            flush_cnt    <= flush_d;
            drain_cnt    <= drain_d;
            underrun_cnt <= under_d;
        end
    end

    // Tag pipeline matches the FIR latency; output stage registers the aligned result
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIR_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
        end else begin
            tag_pipe[0] <= tag_x;
            for (int unsigned i = 1; i < FIR_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            m_valid <= tag_pipe[FIR_LATENCY-1].v;
            m_last  <= tag_pipe[FIR_LATENCY-1].l;
            m_data  <= tag_pipe[FIR_LATENCY-1].v ? fir_dataout : '0;
        end
    end

endmodule

// File: tb/tb_fir_stream_feeder.sv
// Bench for fir_stream_feeder. The FIR is stood in for by a FIR_LATENCY-stage
// delay line whose output is y = x + 1, so every tagged beat has a known value
// (a zero tail sample yields 1) and untagged beats must be masked to 0.
module tb_fir_stream_feeder;

    localparam int unsigned DATA_W      = 13;
    localparam int unsigned FIFO_DEPTH  = 16;
    localparam int unsigned NUM_TAPS    = 34;
    localparam int unsigned FIR_LATENCY = 68;
    localparam int unsigned CNT_W       = 16;
    localparam int          LAT         = 68;
    localparam int          TAIL        = 33;

    typedef struct packed {
        logic              l;
        logic [DATA_W-1:0] d;
    } beat_t;

    typedef struct packed {
        int                         n;
        logic [3:0][DATA_W-1:0]     d;
        logic [3:0][DATA_W-1:0]     y;
        int                         beats;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic [DATA_W-1:0] fir_x;
    logic [DATA_W-1:0] fir_dataout;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic [CNT_W-1:0]  underrun_cnt;
    logic              busy;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    int    bc_q[$];
    int    lc_q[$];
    int    busy_fall_cyc = -1;
    logic  busy_prev = 1'b0;
    vec_t  tbl [5];

    fir_stream_feeder #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .NUM_TAPS    (NUM_TAPS),
        .FIR_LATENCY (FIR_LATENCY),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .fir_x        (fir_x),
        .fir_dataout  (fir_dataout),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_last       (m_last),
        .underrun_cnt (underrun_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] fir_y(input logic [DATA_W-1:0] x);
        return x + DATA_W'(1);
    endfunction

    // Stand-in FIR: pure delay of LAT registers plus a +1 offset
    logic [DATA_W-1:0] dl [LAT];
    always @(posedge clk) begin
        dl[0] <= fir_x;
        for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
    assign fir_dataout = fir_y(dl[LAT-1]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin : mon
        beat_t e;
        if (!rst) begin
            if (m_valid) begin
                bc_q.push_back(cyc);
                if (m_last) lc_q.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got data=%0d last=%0d, none expected (cycle %0d)",
                             m_data, m_last, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== {e.l, e.d}) begin
                        errors++;
                        $display("FAIL beat: got data=%0d last=%0d expected data=%0d last=%0d (cycle %0d)",
                                 m_data, m_last, e.d, e.l, cyc);
                    end
                end
            end else begin
                chk("idle_out_zero", {m_last, m_data}, '0);
            end
            if (busy_prev && !busy) busy_fall_cyc = cyc;
        end
        busy_prev = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one word until accepted; queues its expected beat and, on last, the tail
    task automatic push_word(input logic [DATA_W-1:0] d, input logic last,
                             input logic [DATA_W-1:0] y, output int acc_cyc, output int stall);
        bit acc;
        acc     = 1'b0;
        stall   = 0;
        acc_cyc = -1;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!acc && stall < 1000) begin
            acc = s_ready;
            if (acc) acc_cyc = cyc;
            tick(1);
            if (!acc) stall++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("push_accept", 32'(acc), 1);
        if (acc) begin
            exp_q.push_back('{l: 1'b0, d: y});
            if (last) begin
                for (int k = 0; k < TAIL; k++)
                    exp_q.push_back('{l: (k == TAIL - 1), d: fir_y('0)});
            end
        end
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < bound) begin
            tick(1);
            n++;
        end
        chk("drain_in_time", 32'(n < bound), 1);
        tick(4);
    endtask

    task automatic run_row(input int r);
        int acc0, a, st;
        acc0 = -1;
        bc_q.delete();
        lc_q.delete();
        busy_fall_cyc = -1;
        for (int i = 0; i < tbl[r].n; i++) begin
            push_word(tbl[r].d[i], (i == tbl[r].n - 1), tbl[r].y[i], a, st);
            if (i == 0) acc0 = a;
        end
        wait_idle(400);
        chk($sformatf("row%0d_beats", r), bc_q.size(), tbl[r].beats);
        chk($sformatf("row%0d_one_last", r), lc_q.size(), 1);
        // From IDLE: one wake-up cycle, then pop, fir_x, LAT, output register
        if (bc_q.size() > 0) chk($sformatf("row%0d_first_latency", r), bc_q[0], acc0 + LAT + 4);
        if (lc_q.size() > 0) chk($sformatf("row%0d_busy_fall", r), busy_fall_cyc, lc_q[0] - 1);
    endtask

    initial begin : global_timeout
        #400000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int a, st, stall_pre, stall16;
        int acc_s [5];
        logic [DATA_W-1:0] dv;

        // Vector table: {samples, hand-computed outputs y=x+1, expected beat count}
        for (int r = 0; r < 5; r++) tbl[r] = '0;
        tbl[0].n = 1; tbl[0].d[0] = 13'd2048;  tbl[0].y[0] = 13'd2049;  tbl[0].beats = 34;
        tbl[1].n = 1; tbl[1].d[0] = 13'h0FFF;  tbl[1].y[0] = 13'h1000;  tbl[1].beats = 34;
        tbl[2].n = 1; tbl[2].d[0] = 13'h1000;  tbl[2].y[0] = 13'h1001;  tbl[2].beats = 34;
        tbl[3].n = 2; tbl[3].d[0] = 13'h1FFF;  tbl[3].y[0] = 13'h0000;
                      tbl[3].d[1] = 13'd7;     tbl[3].y[1] = 13'd8;     tbl[3].beats = 35;
        tbl[4].n = 4; tbl[4].d[0] = 13'd5;     tbl[4].y[0] = 13'd6;
                      tbl[4].d[1] = 13'h1FFB;  tbl[4].y[1] = 13'h1FFC;
                      tbl[4].d[2] = 13'd100;   tbl[4].y[2] = 13'd101;
                      tbl[4].d[3] = 13'd0;     tbl[4].y[3] = 13'd1;     tbl[4].beats = 37;

        // Reset held 3 cycles with s_valid asserted
        rst = 1'b1; s_valid = 1'b1; s_data = 13'h0AB; s_last = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick(1);
            chk("rst_fir_x", fir_x, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_m_last", m_last, 0);
            chk("rst_underrun", underrun_cnt, 0);
            chk("rst_busy", busy, 0);
            chk("rst_s_ready", s_ready, 0);
        end
        tick(1);
        rst = 1'b0; s_valid = 1'b0;
        #1;
        chk("post_rst_s_ready", s_ready, 1);
        tick(2);
        chk("post_rst_busy", busy, 0);

        for (int r = 0; r < 5; r++) run_row(r);

        // Backpressure: 1-sample block, then 20 words buffered during its flush/drain
        bc_q.delete(); lc_q.delete();
        stall_pre = 0; stall16 = 0;
        push_word(13'd123, 1'b1, fir_y(13'd123), a, st);
        for (int i = 0; i < 20; i++) begin
            dv = DATA_W'(i * 37 - 300);
            push_word(dv, (i == 19), fir_y(dv), a, st);
            if (i < 16) stall_pre += st;
            if (i == 16) stall16 = st;
            if (i == 15) chk("bp_ready_drop", s_ready, 0);
        end
        chk("bp_first16_no_stall", stall_pre, 0);
        chk("bp_word17_stalled", 32'(stall16 > 0), 1);
        wait_idle(800);
        chk("bp_beats", bc_q.size(), 34 + 20 + TAIL);
        chk("bp_lasts", lc_q.size(), 2);

        // Back-to-back: B pushed while A is flushing, B must start after A's drain
        bc_q.delete(); lc_q.delete();
        for (int i = 0; i < 4; i++) begin
            dv = DATA_W'(11 * (i + 1) * ((i % 2 == 0) ? 1 : -1));
            push_word(dv, (i == 3), fir_y(dv), a, st);
        end
        tick(12);
        for (int i = 0; i < 3; i++) begin
            dv = DATA_W'(200 + i);
            push_word(dv, (i == 2), fir_y(dv), a, st);
        end
        wait_idle(800);
        chk("b2b_beats", bc_q.size(), 37 + 36);
        chk("b2b_lasts", lc_q.size(), 2);
        if (bc_q.size() >= 38 && lc_q.size() >= 1) begin
            chk("b2b_a_last_is_beat37", bc_q[36], lc_q[0]);
            chk("b2b_b_after_drain", bc_q[37], lc_q[0] + LAT + 2);
        end

        // Underrun: samples 3 cycles apart; first one also wakes the FSM from IDLE
        rst = 1'b1; tick(2); rst = 1'b0; tick(3);
        bc_q.delete(); lc_q.delete();
        for (int k = 0; k < 5; k++) begin
            dv = DATA_W'(1000 + 50 * k);
            push_word(dv, 1'b0, fir_y(dv), a, st);
            acc_s[k] = a;
            if (k < 4) tick(3);
        end
        // Starved cycles so far: 2 + 3 + 3 + 3
        chk("ur_after_5", underrun_cnt, 11);
        tick(1);
        push_word(13'd77, 1'b1, fir_y(13'd77), a, st);
        wait_idle(400);
        chk("ur_total", underrun_cnt, 12);
        chk("ur_beats", bc_q.size(), 6 + TAIL);
        if (bc_q.size() > 1) chk("ur_stream_latency", bc_q[1], acc_s[1] + LAT + 3);

        // Reset during FLUSH drops the block entirely
        bc_q.delete(); lc_q.delete();
        push_word(13'd2048, 1'b1, 13'd2049, a, st);
        tick(9);
        rst = 1'b1;
        exp_q.delete();
        tick(1);
        rst = 1'b0;
        tick(LAT + 10);
        chk("mrst_no_beats", bc_q.size(), 0);
        chk("mrst_m_valid", m_valid, 0);
        chk("mrst_underrun", underrun_cnt, 0);
        chk("mrst_idle", busy, 0);
        chk("mrst_s_ready", s_ready, 1);
        run_row(0);

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
